// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload modes, level interrupt request.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_flag, flag_n;
  logic [1:0]  sel;
  logic        en;
  logic        reload;
  logic        unused;

  assign sel    = Addr[1:0];
  assign en     = ctrl[0];
  assign reload = (ctrl[2:1] == 2'b01);
  assign IRQ    = ctrl[3] & irq_flag;
  assign unused = ^Addr[29:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= flag_n;
    end
  end

  // A bus write always wins: the FSM is frozen for that cycle.
  always_comb begin
    state_n  = state;
    ctrl_n   = ctrl;
    preset_n = preset;
    count_n  = count;
    flag_n   = irq_flag;
    if (WE) begin
      unique case (sel)
        2'd0: begin
          ctrl_n = Din[3:0];
          flag_n = 1'b0;
        end
        2'd1: preset_n = Din;
        2'd2: ;
        2'd3: ;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            flag_n  = 1'b0;
            state_n = LOAD;
          end
        end
        LOAD: begin
          count_n = preset;
          state_n = CNT;
        end
        CNT: begin
          if (!en) begin
            state_n = IDLE;
          end else if (count > 32'd1) begin
            count_n = count - 32'd1;
          end else begin
            count_n = '0;
            flag_n  = 1'b1;
            state_n = INT;
          end
        end
        INT: begin
          if (reload) begin
            flag_n = 1'b0;
          end else begin
            ctrl_n[0] = 1'b0;
          end
          state_n = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    unique case (sel)
      2'd0: Dout = {28'b0, ctrl};
      2'd1: Dout = preset;
      2'd2: Dout = count;
      2'd3: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload,
// masking, write-freeze, EN abort and reset behaviour.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int vectors = 0;
  int errs = 0;

  localparam logic [29:0] BASE = 30'h1FC0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    Addr = BASE | {28'b0, r};
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp,
                    input string tag);
    Addr = BASE | {28'b0, r};
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic irq_is(input logic exp, input string tag);
    chk(tag, {31'b0, IRQ}, {31'b0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int ptab [5];
    int ph;
    ptab = '{2, 1, 0, 0, 0};

    // 1: reset state
    do_reset();
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    irq_is(1'b0, "rst_irq");

    // 2: one-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, 32'd3, "os_cnt_e2");
    tick();
    rd(2'd2, 32'd2, "os_cnt_e3");
    tick();
    rd(2'd2, 32'd1, "os_cnt_e4");
    irq_is(1'b0, "os_irq_e4");
    tick();
    rd(2'd2, 32'd0, "os_cnt_e5");
    irq_is(1'b1, "os_irq_e5");
    tick();
    rd(2'd0, 32'h8, "os_ctrl_e6");
    irq_is(1'b1, "os_irq_e6");
    tick();
    irq_is(1'b1, "os_irq_hold");
    wr(2'd0, 32'h8);
    irq_is(1'b0, "os_irq_clr");

    // 3: auto-reload, PRESET=2, period 5
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      ph = (k - 2) % 5;
      if (k < 2) begin
        rd(2'd2, 32'd0, "ar_cnt_e1");
        irq_is(1'b0, "ar_irq_e1");
      end else begin
        rd(2'd2, ptab[ph], $sformatf("ar_cnt_e%0d", k));
        irq_is(ph == 2, $sformatf("ar_irq_e%0d", k));
      end
    end
    rd(2'd0, 32'hB, "ar_ctrl");

    // 4: masked interrupt, PRESET=1, IM=0
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    tick();
    tick();
    rd(2'd2, 32'd1, "mk_cnt_e2");
    tick();
    irq_is(1'b0, "mk_irq_e3");
    tick();
    rd(2'd0, 32'h0, "mk_ctrl_e4");
    irq_is(1'b0, "mk_irq_e4");
    wr(2'd0, 32'h8);
    irq_is(1'b0, "mk_irq_im");
    tick();
    irq_is(1'b0, "mk_irq_im2");

    // 5: write freeze and EN abort
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    rd(2'd2, 32'd4, "wf_cnt_e3");
    Addr = BASE | 30'd1;
    Din  = 32'd9;
    WE   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wf_hold", Dout, 32'd9);
    end
    WE = 1'b0;
    rd(2'd2, 32'd4, "wf_cnt_held");
    tick();
    rd(2'd2, 32'd3, "wf_cnt_run");
    wr(2'd2, 32'hFFFF);
    rd(2'd2, 32'd3, "wf_cnt_ro");
    wr(2'd3, 32'h1234);
    rd(2'd3, 32'd0, "wf_rsvd");
    rd(2'd2, 32'd3, "wf_cnt_rsvd");
    tick();
    rd(2'd2, 32'd2, "wf_cnt_dec");
    wr(2'd0, 32'h8);
    tick();
    for (int k = 0; k < 6; k++) tick();
    rd(2'd2, 32'd2, "ab_cnt_frz");
    rd(2'd1, 32'd9, "ab_preset");
    irq_is(1'b0, "ab_irq");

    // 6: PRESET=0 behaves as PRESET=1, then reset drops IRQ
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    irq_is(1'b0, "z_irq_e2");
    tick();
    irq_is(1'b1, "z_irq_e3");
    rd(2'd2, 32'd0, "z_cnt_e3");
    do_reset();
    irq_is(1'b0, "z_irq_rst");
    rd(2'd0, 32'd0, "z_ctrl_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
